// File: rtl/det_item_table_pkg.sv
// Shared constants for the detection item table.
// Field offsets, frame geometry and empty-slot values.
package det_item_table_pkg;

  localparam int POSITION_WIDTH = 10;
  localparam int OV5640_X = 640;
  localparam int OV5640_Y = 480;

  localparam int SLOTS = 16;

  localparam int X_LSB = 26;
  localparam int Y_LSB = 16;
  localparam int W_LSB = 8;
  localparam int H_LSB = 0;

  localparam logic [31:0] EMPTY_ITEM  = 32'h0;
  localparam logic [3:0]  EMPTY_LABEL = 4'h0;

  // Glyphs drawn below this row would cross the frame bottom.
  localparam int Y_LIMIT = OV5640_Y - 128;

endpackage

// File: rtl/det_dup_check.sv
// 16-way near-duplicate compare of a candidate item
// against the occupied slots of the shadow table.
module det_dup_check
  import det_item_table_pkg::*;
#(
  parameter int P_DUP_TOL = 1
) (
  input  logic [31:0]         cand_item,
  input  logic [3:0]          cand_label,
  input  logic [SLOTS*32-1:0] tbl_item,
  input  logic [SLOTS*4-1:0]  tbl_label,
  input  logic [SLOTS-1:0]    occ,
  output logic                dup,
  output logic [3:0]          match_idx
);

  logic [5:0] cx, tx;
  logic [7:0] cy, ty;
  logic [7:0] dx, dy;
  logic       unused_bits;

  assign cx = cand_item[X_LSB +: 6];
  assign cy = cand_item[Y_LSB +: 8];
  assign unused_bits = ^{cand_item, tbl_item};

  // Descending scan so the lowest matching slot wins.
  always_comb begin
    dup       = 1'b0;
    match_idx = '0;
    tx        = '0;
    ty        = '0;
    dx        = '0;
    dy        = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      tx = tbl_item[k*32 + X_LSB +: 6];
      ty = tbl_item[k*32 + Y_LSB +: 8];
      dx = (cx > tx) ? 8'(cx - tx) : 8'(tx - cx);
      dy = (cy > ty) ? (cy - ty) : (ty - cy);
      if (occ[k]
          && tbl_label[k*4 +: 4] == cand_label
          && dx <= 8'(P_DUP_TOL)
          && dy <= 8'(P_DUP_TOL)) begin
        dup       = 1'b1;
        match_idx = 4'(k);
      end
    end
  end

endmodule

// File: rtl/det_item_table.sv
// Double-buffered 16-slot detection table with dedupe
// and overflow flag, committed once per frame.
module det_item_table
  import det_item_table_pkg::*;
#(
  parameter int P_W       = POSITION_WIDTH,
  parameter int P_SLOTS   = SLOTS,
  parameter int P_DUP_TOL = 1
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           i_frame_end,
  input  logic           i_det_valid,
  input  logic [P_W-1:0] i_det_x,
  input  logic [P_W-1:0] i_det_y,
  input  logic [P_W-1:0] i_det_w,
  input  logic [P_W-1:0] i_det_h,
  input  logic [3:0]     i_det_label,
  output logic [63:0]    o_label,
  output logic [511:0]   o_item,
  output logic [4:0]     o_count,
  output logic           o_overflow
);

  function automatic logic [7:0] sat8(
    input logic [P_W-1:0] v
  );
    logic [P_W-1:0] q;
    q = v >> 2;
    return (|q[P_W-1:8]) ? 8'hFF : q[7:0];
  endfunction

  logic [31:0]  pk_item;
  logic         pk_keep;
  logic         unused_in;

  logic         s1_vld, s2_vld;
  logic [31:0]  s1_item, s2_item;
  logic [3:0]   s1_label, s2_label;

  logic [511:0] sh_item, sh_item_nxt;
  logic [63:0]  sh_label, sh_label_nxt;
  logic [4:0]   wr_ptr, wr_ptr_nxt;
  logic         ovf_sh, ovf_sh_nxt;

  logic [SLOTS-1:0] occ;
  logic             dup;
  logic [3:0]       dup_idx_unused;

  assign unused_in = ^{i_det_x, i_det_w, i_det_h};

  always_comb begin
    pk_item = EMPTY_ITEM;
    pk_item[X_LSB +: 6] = i_det_x[9:4] + 6'd1;
    pk_item[Y_LSB +: 8] = i_det_y[9:2];
    pk_item[W_LSB +: 8] = sat8(i_det_w);
    pk_item[H_LSB +: 8] = sat8(i_det_h);
  end

  assign pk_keep = i_det_y < P_W'(Y_LIMIT);

  always_comb begin
    occ = '0;
    for (int k = 0; k < SLOTS; k++)
      occ[k] = 5'(k) < wr_ptr;
  end

  det_dup_check #(
    .P_DUP_TOL (P_DUP_TOL)
  ) u_dup (
    .cand_item  (s2_item),
    .cand_label (s2_label),
    .tbl_item   (sh_item),
    .tbl_label  (sh_label),
    .occ        (occ),
    .dup        (dup),
    .match_idx  (dup_idx_unused)
  );

  always_comb begin
    sh_item_nxt  = sh_item;
    sh_label_nxt = sh_label;
    wr_ptr_nxt   = wr_ptr;
    ovf_sh_nxt   = ovf_sh;
    if (s2_vld && !dup) begin
      if (wr_ptr < 5'(P_SLOTS)) begin
        sh_item_nxt[wr_ptr[3:0]*32 +: 32] = s2_item;
        sh_label_nxt[wr_ptr[3:0]*4 +: 4]  = s2_label;
        wr_ptr_nxt = wr_ptr + 5'd1;
      end else begin
        ovf_sh_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_vld     <= 1'b0;
      s1_item    <= EMPTY_ITEM;
      s1_label   <= EMPTY_LABEL;
      s2_vld     <= 1'b0;
      s2_item    <= EMPTY_ITEM;
      s2_label   <= EMPTY_LABEL;
      sh_item    <= {SLOTS{EMPTY_ITEM}};
      sh_label   <= {SLOTS{EMPTY_LABEL}};
      wr_ptr     <= '0;
      ovf_sh     <= 1'b0;
      o_item     <= {SLOTS{EMPTY_ITEM}};
      o_label    <= {SLOTS{EMPTY_LABEL}};
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      s1_vld   <= i_det_valid && pk_keep;
      s1_item  <= pk_item;
      s1_label <= i_det_label;
      s2_vld   <= s1_vld;
      s2_item  <= s1_item;
      s2_label <= s1_label;
      if (i_frame_end) begin
        o_item     <= sh_item_nxt;
        o_label    <= sh_label_nxt;
        o_count    <= wr_ptr_nxt;
        o_overflow <= ovf_sh_nxt;
        sh_item    <= {SLOTS{EMPTY_ITEM}};
        sh_label   <= {SLOTS{EMPTY_LABEL}};
        wr_ptr     <= '0;
        ovf_sh     <= 1'b0;
      end else begin
        sh_item  <= sh_item_nxt;
        sh_label <= sh_label_nxt;
        wr_ptr   <= wr_ptr_nxt;
        ovf_sh   <= ovf_sh_nxt;
      end
    end
  end

endmodule

// File: tb/tb_det_item_table.sv
// Directed bench for det_item_table with a
// reference table model and a commit scoreboard.
module tb_det_item_table;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         i_frame_end;
  logic         i_det_valid;
  logic [9:0]   i_det_x, i_det_y, i_det_w, i_det_h;
  logic [3:0]   i_det_label;
  logic [63:0]  o_label;
  logic [511:0] o_item;
  logic [4:0]   o_count;
  logic         o_overflow;

  always #5 sys_clk = ~sys_clk;

  det_item_table dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .i_frame_end (i_frame_end),
    .i_det_valid (i_det_valid),
    .i_det_x     (i_det_x),
    .i_det_y     (i_det_y),
    .i_det_w     (i_det_w),
    .i_det_h     (i_det_h),
    .i_det_label (i_det_label),
    .o_label     (o_label),
    .o_item      (o_item),
    .o_count     (o_count),
    .o_overflow  (o_overflow)
  );

  typedef struct {
    logic [511:0] item;
    logic [63:0]  label;
    logic [4:0]   count;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_item[16];
  logic [3:0]  m_lab[16];
  int          m_cnt;
  bit          m_ovf;
  int          last_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] sat(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  function automatic logic [31:0] pack(input int x, y, w, h);
    logic [5:0] xf;
    xf = 6'((x >> 4) + 1);
    return {xf, 2'b00, 8'(y >> 2), sat(w >> 2), sat(h >> 2)};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_item[i] = '0;
      m_lab[i]  = '0;
    end
    m_cnt = 0;
    m_ovf = 0;
  endtask

  task automatic model_add(input int x, y, w, h, input logic [3:0] l);
    logic [31:0] it;
    if (y >= 352) return;
    it = pack(x, y, w, h);
    for (int i = 0; i < m_cnt; i++)
      if (m_lab[i] == l
          && iabs(int'(m_item[i][31:26]) - int'(it[31:26])) <= 1
          && iabs(int'(m_item[i][23:16]) - int'(it[23:16])) <= 1)
        return;
    if (m_cnt < 16) begin
      m_item[m_cnt] = it;
      m_lab[m_cnt]  = l;
      m_cnt++;
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic model_commit();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.item[i*32 +: 32] = m_item[i];
      e.label[i*4 +: 4]  = m_lab[i];
    end
    e.count  = 5'(m_cnt);
    e.ovf    = m_ovf;
    last_cnt = m_cnt;
    sb.push_back(e);
    model_clear();
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic rec(input int x, y, w, h, input logic [3:0] l);
    i_det_valid = 1'b1;
    i_det_x     = 10'(x);
    i_det_y     = 10'(y);
    i_det_w     = 10'(w);
    i_det_h     = 10'(h);
    i_det_label = l;
    cyc();
    i_det_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [511:0] got, exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic check_commit(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".item"},  o_item, e.item);
    chk({tag, ".label"}, 512'(o_label), 512'(e.label));
    chk({tag, ".count"}, 512'(o_count), 512'(e.count));
    chk({tag, ".ovf"},   512'(o_overflow), 512'(e.ovf));
  endtask

  task automatic fend(input string tag);
    model_commit();
    i_frame_end = 1'b1;
    cyc();
    i_frame_end = 1'b0;
    check_commit(tag);
  endtask

  initial begin
    sys_rst     = 1'b1;
    i_frame_end = 1'b0;
    i_det_valid = 1'b0;
    i_det_x     = '0;
    i_det_y     = '0;
    i_det_w     = '0;
    i_det_h     = '0;
    i_det_label = '0;
    model_clear();
    idle(2);
    chk("rst.item",  o_item, '0);
    chk("rst.label", 512'(o_label), '0);
    chk("rst.count", 512'(o_count), '0);
    chk("rst.ovf",   512'(o_overflow), '0);
    sys_rst = 1'b0;
    idle(1);
    fend("empty");

    rec(100, 40, 64, 32, 4'd3);
    model_add(100, 40, 64, 32, 4'd3);
    idle(3);
    fend("single");
    chk("single.lit_item", 512'(o_item[31:0]), 512'(32'h1C0A1008));
    chk("single.lit_lab",  512'(o_label[3:0]), 512'(4'd3));
    chk("single.lit_cnt",  512'(o_count), 512'(5'd1));

    rec(100, 40, 64, 32, 4'd3);
    rec(116, 44, 64, 32, 4'd3);
    rec(100, 40, 64, 32, 4'd5);
    model_add(100, 40, 64, 32, 4'd3);
    model_add(116, 44, 64, 32, 4'd3);
    model_add(100, 40, 64, 32, 4'd5);
    idle(3);
    fend("dedupe");
    chk("dedupe.lit_cnt", 512'(o_count), 512'(5'd2));
    chk("dedupe.lit_lab1", 512'(o_label[7:4]), 512'(4'd5));

    for (int k = 0; k < 20; k++) begin
      rec(32 * k, 0, 16, 16, 4'd1);
      model_add(32 * k, 0, 16, 16, 4'd1);
    end
    idle(3);
    chk("stable.count", 512'(o_count), 512'(last_cnt));
    fend("ovf");
    chk("ovf.lit_cnt", 512'(o_count), 512'(5'd16));
    chk("ovf.lit_flag", 512'(o_overflow), 512'(1'b1));
    chk("ovf.lit_x15", 512'(o_item[511:506]), 512'(6'd31));
    fend("ovf_clear");
    chk("ovf_clear.lit", 512'(o_overflow), 512'(1'b0));

    rec(200, 352, 40, 40, 4'd2);
    model_add(200, 352, 40, 40, 4'd2);
    idle(3);
    fend("y_drop");
    chk("y_drop.lit_cnt", 512'(o_count), 512'(5'd0));
    rec(200, 351, 40, 40, 4'd2);
    model_add(200, 351, 40, 40, 4'd2);
    idle(3);
    fend("y_keep");
    chk("y_keep.lit_cnt", 512'(o_count), 512'(5'd1));

    rec(300, 100, 48, 48, 4'd6);
    fend("coll_t1");
    model_add(300, 100, 48, 48, 4'd6);
    idle(3);
    fend("coll_next");
    chk("coll_next.lit_lab", 512'(o_label[3:0]), 512'(4'd6));
    rec(400, 200, 24, 24, 4'd7);
    model_add(400, 200, 24, 24, 4'd7);
    idle(1);
    fend("coll_t2");
    chk("coll_t2.lit_cnt", 512'(o_count), 512'(5'd1));

    rec(500, 120, 32, 32, 4'd4);
    idle(3);
    sys_rst = 1'b1;
    idle(1);
    sys_rst = 1'b0;
    chk("midrst.item",  o_item, '0);
    chk("midrst.count", 512'(o_count), '0);
    model_clear();
    fend("midrst_fe");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
